// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO that uses all 2^ADDR_LENGTH entries. It provides an occupancy
// count, programmable almost-full/almost-empty thresholds, sticky overflow and
// underflow flags, a synchronous flush, and either a registered or a
// first-word-fall-through read port.
module sync_fifo_flags #(
  parameter int ADDR_LENGTH     = 4,
  parameter int WORD_LENGTH     = 8,
  parameter int ALMOST_FULL_TH  = 2**ADDR_LENGTH - 2,
  parameter int ALMOST_EMPTY_TH = 2,
  parameter bit FWFT            = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [WORD_LENGTH-1:0] data_in,
  input  logic                   write_en,
  input  logic                   read_en,
  output logic [WORD_LENGTH-1:0] data_out,
  output logic                   valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [ADDR_LENGTH:0]   count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int DEPTH = 2**ADDR_LENGTH;
  localparam logic [ADDR_LENGTH:0] DEPTH_C = (ADDR_LENGTH+1)'(DEPTH);
  localparam logic [ADDR_LENGTH:0] AF_TH   = (ADDR_LENGTH+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_LENGTH:0] AE_TH   = (ADDR_LENGTH+1)'(ALMOST_EMPTY_TH);

  logic [WORD_LENGTH-1:0] mem_q [DEPTH];
  logic [ADDR_LENGTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_LENGTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_LENGTH:0]   count_q, count_d;
  logic [WORD_LENGTH-1:0] dout_q, dout_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic                   rd_ok, wr_ok, mem_we;

  // The count is held in its own register, so full and empty need no extra
  // pointer wrap bit and every entry is usable.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_TH);
  assign almost_empty = (count_q <= AE_TH);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A read frees a slot in the same cycle, so a full FIFO can still accept a
  // write when a read is also accepted.
  assign rd_ok  = read_en && !empty;
  assign wr_ok  = write_en && (!full || rd_ok);
  assign mem_we = wr_ok && !flush;

  // The FWFT port shows the head entry directly. The registered port shows the last popped word.
  assign data_out = FWFT ? mem_q[rd_ptr_q] : dout_q;
  assign valid    = FWFT ? !empty : valid_q;

  // Next-state logic. Flush discards any same-cycle request and leaves the error flags unchanged.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        dout_d   = mem_q[rd_ptr_q];
        valid_d  = 1'b1;
      end
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
      else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
      if (write_en && !wr_ok) ovf_d = 1'b1;
      if (read_en && empty)   unf_d = 1'b1;
    end
  end

  // Control state. Reset has priority over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array. It is never cleared. Reset and flush only move the pointers.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed and random stimulus for sync_fifo_flags. Two instances, one with the
// registered read port and one with the FWFT read port, share the same inputs.
// A queue model and a scoreboard of popped words check both instances after every clock edge.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       reset = 1'b1, flush = 1'b0, write_en = 1'b0, read_en = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] dout0, dout1;
  logic       valid0, valid1, full0, full1, empty0, empty1;
  logic       af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
  logic [4:0] cnt0, cnt1;

  always #5 clk = ~clk;

  sync_fifo_flags #(.FWFT(1'b0)) u_std (
    .clk(clk), .reset(reset), .flush(flush), .data_in(data_in),
    .write_en(write_en), .read_en(read_en), .data_out(dout0), .valid(valid0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ovf0), .underflow(unf0));

  sync_fifo_flags #(.FWFT(1'b1)) u_fwft (
    .clk(clk), .reset(reset), .flush(flush), .data_in(data_in),
    .write_en(write_en), .read_en(read_en), .data_out(dout1), .valid(valid1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ovf1), .underflow(unf1));

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] model_q[$];
  logic [7:0] sb_q[$];
  logic       m_ovf = 1'b0, m_unf = 1'b0;
  logic [7:0] m_last = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model, then check both instances after the edge.
  task automatic step(input bit rs, input bit fl, input bit we, input bit re, input logic [7:0] din);
    bit   rd_ok, wr_ok, exp_v0;
    int   sz;
    logic [7:0] w;
    @(negedge clk);
    reset = rs; flush = fl; write_en = we; read_en = re; data_in = din;
    sz     = model_q.size();
    rd_ok  = re && sz != 0;
    wr_ok  = we && (sz != 16 || rd_ok);
    exp_v0 = 1'b0;
    if (rs) begin
      model_q.delete(); sb_q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_last = 8'h00;
    end else if (fl) begin
      model_q.delete();
    end else begin
      if (we && !wr_ok) m_ovf = 1'b1;
      if (re && sz == 0) m_unf = 1'b1;
      if (rd_ok) begin
        sb_q.push_back(model_q.pop_front());
        exp_v0 = 1'b1;
      end
      if (wr_ok) model_q.push_back(din);
    end
    @(posedge clk);
    #1;
    sz = model_q.size();
    chk("count",  32'(cnt0),  32'(sz));
    chk("full",   32'(full0), 32'(sz == 16));
    chk("empty",  32'(empty0), 32'(sz == 0));
    chk("afull",  32'(af0),   32'(sz >= 14));
    chk("aempty", 32'(ae0),   32'(sz <= 2));
    chk("ovf",    32'(ovf0),  32'(m_ovf));
    chk("unf",    32'(unf0),  32'(m_unf));
    chk("valid_std", 32'(valid0), 32'(exp_v0));
    if (exp_v0 && sb_q.size() != 0) begin
      w = sb_q.pop_front();
      m_last = w;
    end
    chk("dout_std", 32'(dout0), 32'(m_last));
    chk("count_fwft", 32'(cnt1), 32'(sz));
    chk("flags_fwft", {27'd0, full1, empty1, af1, ae1, ovf1 | unf1},
        {27'd0, sz == 16, sz == 0, sz >= 14, sz <= 2, m_ovf | m_unf});
    chk("valid_fwft", 32'(valid1), 32'(sz != 0));
    if (sz != 0) chk("dout_fwft", 32'(dout1), 32'(model_q[0]));
  endtask

  initial begin
    int guard;
    // Reset
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    // Fill with 0x00..0x0F
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 8'(i));
    // Write at full sets sticky overflow
    step(0, 0, 1, 0, 8'hEE);
    // Full with simultaneous read/write for 20 cycles
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1, 8'(8'h40 + i));
    // Drain, then read at empty
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    // Reset clears the sticky flags
    step(1, 0, 0, 0, 8'h00);
    // Single 0xA5 write, then read
    step(0, 0, 1, 0, 8'hA5);
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    // Underflow, then 5 words, then flush with a simultaneous write
    step(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'(8'h70 + i));
    step(0, 1, 1, 1, 8'hBB);
    step(0, 0, 0, 0, 8'h00);
    // Wrap the pointers: three fill/drain passes with random gaps
    for (int k = 0; k < 3; k++) begin
      guard = 0;
      while (model_q.size() < 16 && guard < 400) begin
        step(0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 8'($urandom));
        guard++;
      end
      chk("fill_reached", 32'(model_q.size()), 32'd16);
      guard = 0;
      while (model_q.size() > 0 && guard < 400) begin
        step(0, 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
        guard++;
      end
      chk("drain_reached", 32'(model_q.size()), 32'd0);
    end
    // Reset asserted mid-stream
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'(8'hC0 + i));
    step(1, 0, 1, 1, 8'hCC);
    step(0, 0, 0, 0, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Single-clock, parametrised FIFO with full-depth usage (all 2^ADDR_LENGTH entries usable), an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a selectable standard or first-word-fall-through (FWFT) read mode. It is the general-purpose buffer between same-clock producers and consumers (serial-interface RX/TX paths, command queues). It replaces ad-hoc pointer-compare FIFOs that lose one entry of depth.

## Interface
- ADDR_LENGTH, 4, log2 of depth; DEPTH = 2^ADDR_LENGTH entries, all usable.
- WORD_LENGTH, 8, data width in bits.
- ALMOST_FULL_TH, 2^ADDR_LENGTH-2, almost_full asserted when count >= this value; legal range 1..DEPTH.
- ALMOST_EMPTY_TH, 2, almost_empty asserted when count <= this value; legal range 0..DEPTH-1.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous empty request; keeps error flags.
- data_in  in  WORD_LENGTH  write data.
- write_en  in  1  write request.
- read_en  in  1  read/pop request.
- data_out  out  WORD_LENGTH  read data.
- valid  out  1  data_out qualifier.
- full, empty  out  1 each  occupancy flags.
- almost_full, almost_empty  out  1 each  threshold flags.
- count  out  ADDR_LENGTH+1  current occupancy, 0..DEPTH.
- overflow, underflow  out  1 each  sticky error flags.

## Operation
- Storage: internal DEPTH x WORD_LENGTH register array, written synchronously. Read pointer, write pointer and count are all registered.
- Read accepted (rd_ok) = read_en && !empty. There is no read-through of a same-cycle write into an empty FIFO.
- Write accepted (wr_ok) = write_en && (!full || rd_ok). When full, a simultaneous accepted read allows the write.
- Pointers wrap from DEPTH-1 to 0. Count changes by +1 on wr_ok only, by -1 on rd_ok only, and is unchanged when both occur.
- Flags are combinational from count: full = (count == DEPTH); empty = (count == 0); almost_full = (count >= ALMOST_FULL_TH); almost_empty = (count <= ALMOST_EMPTY_TH).
- overflow is set on write_en && !wr_ok. underflow is set on read_en && empty. Both stay set until reset; flush does not clear them.
- FWFT=0: on rd_ok, data_out <= head entry and valid <= 1. Otherwise valid <= 0 and data_out holds its last value.
- FWFT=1: data_out = head entry combinationally; valid = !empty; rd_ok pops. data_out is don't-care while valid = 0.
- Priority: reset > flush > read/write.
- flush: pointers and count go to 0 and valid goes to 0 (FWFT=0). Any same-cycle read or write is discarded, and discarded requests do not set the error flags.

## Timing
- Reset values: count 0, empty 1, full 0, almost_empty 1, almost_full 0, valid 0, data_out 0 (FWFT=0), overflow 0, underflow 0.
- Write latency: an entry written at edge N is readable (rd_ok possible) in cycle N+1. In FWFT=1 it appears on data_out in cycle N+1.
- FWFT=0 read latency: 1 cycle. rd_ok in cycle N gives data_out/valid after edge N for one cycle. Back-to-back reads give one word per cycle.
- Flags and count reflect the state after each edge and are valid in the same cycle; there is no extra flag latency.
- Reset or flush asserted mid-stream takes effect at that edge. Stored contents are not cleared but become unreachable.

## Test plan
- Reset, then 16 writes 0x00..0x0F at ADDR_LENGTH=4 -> full=1 after the 16th edge, count=16, almost_full from count=14, overflow=0.
- Write at full (no read) -> data not stored, count stays 16, overflow=1 and stays set through later traffic until reset.
- Full FIFO with read_en and write_en both asserted for 20 cycles -> count stays 16, output order is 0x00,0x01,... then the new words, no error flags.
- Read at empty -> underflow=1, valid=0. Single write 0xA5 followed by read_en -> FWFT=0: data_out=0xA5 with valid=1 one cycle after rd_ok. FWFT=1: data_out=0xA5 with valid=1 the cycle after the write.
- 5 words stored, flush asserted with a simultaneous write -> count=0, empty=1, almost_empty=1, write discarded, overflow/underflow unchanged.
- Fill and drain 3 times (pointer wrap) with random read/write gaps -> data order and count match a reference queue model every cycle.
